// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC sequencing, one-entry IF/ID register with valid/ready
// toward decode, redirect squash, and HALT detection.
module fetch_stage #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 16'h0000,
    parameter logic [4:0]            HALT_OPCODE = 5'b00000,
    parameter logic [15:0]           NOP_INSTR   = 16'h0800
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_enable,
    output logic                  imem_wr,
    output logic [15:0]           imem_wdata,
    input  logic [15:0]           imem_rdata,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  id_ready,
    output logic                  id_valid,
    output logic [15:0]           id_instr,
    output logic [ADDR_WIDTH-1:0] id_pc_plus2,
    output logic                  halted,
    output logic                  misalign_err,
    output logic [1:0]            state_dbg
);

    // Handshake: a word moves to decode on a rising edge where id_valid and id_ready
    // are both high; id_instr/id_pc_plus2 hold while id_valid is high and id_ready low.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] pc, pc_next, pc_inc, plus2_next;
    logic [15:0]           instr_next;
    logic                  valid_next, misalign_next, advance;

    assign pc_inc      = pc + ADDR_WIDTH'(2);
    assign advance     = !id_valid || id_ready;
    assign imem_addr   = pc;
    assign imem_enable = (state == RUN);
    assign halted      = (state == HALT);
    assign imem_wr     = 1'b0;
    assign imem_wdata  = 16'h0000;
    assign state_dbg   = state;

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        valid_next    = id_valid;
        instr_next    = id_instr;
        plus2_next    = id_pc_plus2;
        misalign_next = misalign_err;
        if (redirect) begin
            // The word in the output register is wrong-path; squash it.
            pc_next       = {redirect_pc[ADDR_WIDTH-1:1], 1'b0};
            valid_next    = 1'b0;
            instr_next    = NOP_INSTR;
            state_next    = RUN;
            misalign_next = misalign_err | redirect_pc[0];
        end else begin
            case (state)
                BOOT: state_next = RUN;
                RUN: begin
                    if (advance) begin
                        instr_next = imem_rdata;
                        plus2_next = pc_inc;
                        valid_next = 1'b1;
                        if (imem_rdata[15:11] == HALT_OPCODE) begin
                            state_next = HALT;
                        end else begin
                            pc_next = pc_inc;
                        end
                    end
                end
                HALT: begin
                    if (id_valid && id_ready) begin
                        valid_next = 1'b0;
                        instr_next = NOP_INSTR;
                    end
                end
                default: state_next = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            id_valid     <= 1'b0;
            id_instr     <= NOP_INSTR;
            id_pc_plus2  <= '0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            id_valid     <= valid_next;
            id_instr     <= instr_next;
            id_pc_plus2  <= plus2_next;
            misalign_err <= misalign_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed walk through fetch, stall, redirect, HALT, wrap and
// reset, then randomized ready/redirect traffic checked against a program-order model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] imem_addr;
    logic        imem_enable;
    logic        imem_wr;
    logic [15:0] imem_wdata;
    logic [15:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        id_ready = 1'b1;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc_plus2;
    logic        halted;
    logic        misalign_err;
    logic [1:0]  state_dbg;

    logic [15:0] mem [0:32767];
    int          tests = 0;
    int          fails = 0;

    localparam logic [1:0]  S_BOOT = 2'd0;
    localparam logic [1:0]  S_RUN  = 2'd1;
    localparam logic [15:0] NOP    = 16'h0800;

    fetch_stage dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_enable(imem_enable),
        .imem_wr(imem_wr), .imem_wdata(imem_wdata), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc_plus2(id_pc_plus2), .halted(halted), .misalign_err(misalign_err),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;
    assign imem_rdata = mem[imem_addr[15:1]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:11] == 5'b00000) w[15:11] = 5'b00001;
        return w;
    endfunction

    initial begin
        logic [15:0] next_addr;
        logic        exp_mis;
        int          accepts;

        for (int i = 0; i < 32768; i++) mem[i] = rand_word();
        mem[0]       = 16'h0800;
        mem[1]       = 16'h4001;
        mem[2]       = 16'h0000;   // HALT at 0x0004
        mem[16'h20]  = 16'h5a5a;   // 0x0040
        mem[16'h7fff] = 16'h1234;  // 0xFFFE

        // Reset held for two edges, then boot
        tick(); tick();
        rst = 1'b0;
        check("boot_enable", imem_enable, 0);
        check("boot_valid", id_valid, 0);
        check("boot_instr", id_instr, NOP);
        check("boot_plus2", id_pc_plus2, 0);
        check("boot_state", state_dbg, S_BOOT);
        tick();
        check("c2_addr", imem_addr, 16'h0000);
        check("c2_enable", imem_enable, 1);
        tick();
        check("c3_instr", id_instr, 16'h0800);
        check("c3_plus2", id_pc_plus2, 16'h0002);
        check("c3_addr", imem_addr, 16'h0002);
        check("c3_valid", id_valid, 1);

        // Stall for three cycles
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_instr", id_instr, 16'h0800);
            check("stall_plus2", id_pc_plus2, 16'h0002);
            check("stall_addr", imem_addr, 16'h0002);
        end
        id_ready = 1'b1;
        tick();
        check("release_instr", id_instr, 16'h4001);
        check("release_plus2", id_pc_plus2, 16'h0004);
        check("release_addr", imem_addr, 16'h0004);

        // HALT fetched from 0x0004
        tick();
        check("halt_instr", id_instr, 16'h0000);
        check("halt_plus2", id_pc_plus2, 16'h0006);
        check("halt_flag", halted, 1);
        check("halt_enable", imem_enable, 0);
        check("halt_addr", imem_addr, 16'h0004);
        id_ready = 1'b0;
        tick();
        check("halt_hold_valid", id_valid, 1);
        id_ready = 1'b1;
        tick();
        check("halt_drain_valid", id_valid, 0);
        check("halt_drain_instr", id_instr, NOP);
        tick();
        check("halt_stays", halted, 1);
        check("halt_addr2", imem_addr, 16'h0004);

        // Redirect out of HALT to 0x0000
        redirect = 1'b1; redirect_pc = 16'h0000;
        tick();
        redirect = 1'b0;
        check("restart_halted", halted, 0);
        check("restart_enable", imem_enable, 1);
        check("restart_addr", imem_addr, 16'h0000);
        check("restart_valid", id_valid, 0);
        tick();
        check("restart_instr", id_instr, 16'h0800);
        check("restart_vld1", id_valid, 1);

        // Redirect while the output register holds a valid word
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        check("redir_valid", id_valid, 0);
        check("redir_instr", id_instr, NOP);
        check("redir_addr", imem_addr, 16'h0040);
        tick();
        check("redir_tgt_instr", id_instr, 16'h5a5a);
        check("redir_tgt_plus2", id_pc_plus2, 16'h0042);
        check("redir_tgt_valid", id_valid, 1);
        check("redir_no_mis", misalign_err, 0);

        // Misaligned redirect, then wrap at the top of memory
        redirect = 1'b1; redirect_pc = 16'h0013;
        tick();
        redirect = 1'b0;
        check("mis_addr", imem_addr, 16'h0012);
        check("mis_flag", misalign_err, 1);
        tick();
        check("mis_instr", id_instr, mem[9]);
        check("mis_sticky", misalign_err, 1);
        redirect = 1'b1; redirect_pc = 16'hfffe;
        tick();
        redirect = 1'b0;
        check("wrap_addr0", imem_addr, 16'hfffe);
        tick();
        check("wrap_instr", id_instr, 16'h1234);
        check("wrap_plus2", id_pc_plus2, 16'h0000);
        check("wrap_addr", imem_addr, 16'h0000);
        check("wrap_sticky", misalign_err, 1);

        // Reset in the middle of a stall
        id_ready = 1'b0;
        tick();
        check("pre_rst_valid", id_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_valid", id_valid, 0);
        check("rst_instr", id_instr, NOP);
        check("rst_plus2", id_pc_plus2, 0);
        check("rst_mis", misalign_err, 0);
        check("rst_state", state_dbg, S_BOOT);
        check("rst_enable", imem_enable, 0);
        check("rst_halted", halted, 0);
        check("rst_addr", imem_addr, 16'h0000);
        tick();
        check("rst_run", state_dbg, S_RUN);
        id_ready = 1'b1;
        tick();
        check("rst_resume_instr", id_instr, 16'h0800);
        check("rst_resume_plus2", id_pc_plus2, 16'h0002);

        // Random ready/redirect traffic: decode must see the program-order walk
        // from each redirect target, with no loss or duplication.
        next_addr = 16'h0000;
        exp_mis   = 1'b0;
        accepts   = 0;
        for (int i = 0; i < 600; i++) begin
            id_ready = ($urandom_range(0, 3) != 0);
            redirect = (i == 0) || ($urandom_range(0, 15) == 0);
            redirect_pc = 16'h0100 + 16'($urandom_range(0, 255));
            check("const_wr", imem_wr, 0);
            check("const_wdata", imem_wdata, 0);
            if (redirect) begin
                next_addr = redirect_pc & 16'hfffe;
                exp_mis   = exp_mis | redirect_pc[0];
            end else if (id_valid && id_ready) begin
                check("rand_instr", id_instr, mem[next_addr[15:1]]);
                check("rand_plus2", id_pc_plus2, next_addr + 16'd2);
                next_addr = next_addr + 16'd2;
                accepts++;
            end
            tick();
        end
        redirect = 1'b0;
        check("rand_mis", misalign_err, exp_mis);
        check("rand_progress", accepts > 200, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage that drives the byte-addressed, 16-bit instruction memory and consumes its combinational read data. It holds the PC and steps it by 2. Each fetched word is registered into a one-entry IF/ID output register with a valid/ready handshake toward decode. The stage also handles branch/jump redirects, stalls, and HALT detection.

Parameters:
ADDR_WIDTH, 16, width of PC and memory address
RESET_PC, 16'h0000, PC value loaded on reset (bit 0 must be 0)
HALT_OPCODE, 5'b00000, value of instr[15:11] that identifies HALT
NOP_INSTR, 16'h0800, instruction placed in id_instr when the output is empty or squashed

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
imem_addr  output  ADDR_WIDTH  byte address to instruction memory; equals current PC
imem_enable  output  1  instruction-memory read enable
imem_wr  output  1  instruction-memory write strobe; constant 0
imem_wdata  output  16  instruction-memory write data; constant 0
imem_rdata  input  16  combinational read data from instruction memory
redirect  input  1  branch/jump taken; load redirect_pc
redirect_pc  input  ADDR_WIDTH  redirect target byte address
id_ready  input  1  decode accepts id_instr this cycle
id_valid  output  1  id_instr/id_pc_plus2 hold a valid fetched instruction
id_instr  output  16  fetched instruction
id_pc_plus2  output  ADDR_WIDTH  address of fetched instruction + 2
halted  output  1  stage has fetched HALT and stopped fetching
misalign_err  output  1  sticky flag: a redirect target had bit 0 set

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high on rst; it is sampled only at the rising edge of clk.
  - Reset values: pc=RESET_PC, state=BOOT, id_valid=0, id_instr=NOP_INSTR, id_pc_plus2=0, misalign_err=0.
  - rst has priority over every other input, including mid-stall and mid-redirect.
- States:
  - BOOT: imem_enable=0. The instruction memory loads its image while rst is high, so BOOT lasts exactly one cycle after rst deasserts, then goes to RUN.
  - RUN: imem_enable=1, imem_addr=pc.
  - HALT: imem_enable=0, halted=1. halted is decoded from state (halted = state==HALT).
- advance = !id_valid | id_ready.
- RUN with advance=1 (and no redirect), on the edge:
  - id_instr<=imem_rdata, id_pc_plus2<=pc+2, id_valid<=1.
  - If imem_rdata[15:11]==HALT_OPCODE: pc holds and state<=HALT.
  - Otherwise pc<=pc+2.
- RUN with advance=0: pc, id_* and state all hold. This gives a zero-bubble stall.
- HALT state:
  - No fetch.
  - id_valid stays 1 until id_ready is sampled high, then goes to 0 with id_instr<=NOP_INSTR.
  - The stage remains in HALT until reset or redirect.
- Redirect (any state except during rst): takes priority over fetch and stall. On the edge:
  - pc<={redirect_pc[ADDR_WIDTH-1:1],1'b0}
  - id_valid<=0, id_instr<=NOP_INSTR (the wrong-path instruction is squashed)
  - state<=RUN (this also leaves HALT and BOOT)
  - misalign_err<=misalign_err|redirect_pc[0]
- Arithmetic: pc+2 wraps modulo 2^ADDR_WIDTH (0xFFFE -> 0x0000). pc bit 0 is always 0.
- Constant outputs: imem_wr=0 and imem_wdata=0 at all times.
- Latency:
  - Address presented in cycle N -> instruction visible on id_instr in cycle N+1.
  - Redirect asserted in cycle N -> target address on imem_addr in N+1 -> target instruction valid in N+2.

Test Plan:
1. Memory 0x0800@0x0000, 0x4001@0x0002, id_ready=1, rst high 2 cycles:
   - Cycle 1 after rst: imem_enable=0, id_valid=0.
   - Cycle 2: imem_addr=0x0000.
   - Cycle 3: id_instr=0x0800, id_pc_plus2=0x0002, imem_addr=0x0002.
2. Stall: id_ready=0 for 3 cycles while id_valid=1 -> id_instr, id_pc_plus2 and imem_addr constant. Release -> next word appears on the following edge, with no loss or duplication.
3. Redirect=1, redirect_pc=0x0040 while id_valid=1 -> next cycle id_valid=0, id_instr=0x0800, imem_addr=0x0040. Following cycle: id_instr=mem[0x0040], id_pc_plus2=0x0042.
4. HALT (0x0000) at 0x0004 -> after capture halted=1, imem_enable=0, imem_addr stays 0x0004. id_valid drops after one id_ready=1 cycle. A later redirect to 0x0000 restarts fetch and sets halted=0.
5. Misaligned and wrap:
   - Redirect to 0x0013 -> imem_addr=0x0012, misalign_err=1. The flag stays 1 until rst.
   - Redirect to 0xFFFE -> id_pc_plus2=0x0000, next imem_addr=0x0000.
6. rst asserted mid-stall with id_valid=1 -> next cycle all outputs at reset values and state=BOOT; fetch resumes from RESET_PC.
